// File: rtl/adder_carry_serial_seq.sv
// Bit-serial WIDTH-bit add/subtract built around one shared adder_carry cell.
// Operands stream LSB first; sum, carry and signed overflow appear with a done pulse.

module adder_carry (
  input  logic p,
  input  logic g,
  input  logic cin,
  output logic sumout,
  output logic cout
);
  assign sumout = p ^ cin;
  assign cout   = g | (p & cin);
endmodule

module adder_carry_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic             op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic             cell_sum;
  logic             cell_cout;

  adder_carry u_cell (
    .p      (sa[0] ^ sb[0]),
    .g      (sa[0] & sb[0]),
    .cin    (cy),
    .sumout (cell_sum),
    .cout   (cell_cout)
  );

  // Written as shift-then-insert so WIDTH=1 needs no zero-width slice.
  always_comb begin
    acc_nxt            = acc >> 1;
    acc_nxt[WIDTH-1]   = cell_sum;
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state    <= IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      sa       <= '0;
      sb       <= '0;
      acc      <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= op ? ~b : b;
            cy    <= op;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            acc <= acc_nxt;
            cy  <= cell_cout;
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            cnt <= cnt + 1'b1;
            // cy on this edge is the carry into the MSB.
            if (cnt == LAST) begin
              sum      <= acc_nxt;
              cout     <= cell_cout;
              overflow <= cy ^ cell_cout;
              state    <= DONE;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_carry_serial_seq.sv
// Scoreboard bench for adder_carry_serial_seq at WIDTH=8 and WIDTH=1.
module tb_adder_carry_serial_seq;
  logic C = 1'b0;
  always #5 C = ~C;

  logic       r8, start8, op8, abort8;
  logic [7:0] a8, b8, sum8;
  logic       ready8, busy8, done8, cout8, ov8;

  logic       r1, start1, op1, abort1;
  logic [0:0] a1, b1, sum1;
  logic       ready1, busy1, done1, cout1, ov1;

  adder_carry_serial_seq #(.WIDTH(8)) dut8 (
    .C(C), .R(r8), .start(start8), .op(op8), .abort(abort8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
  );

  adder_carry_serial_seq #(.WIDTH(1)) dut1 (
    .C(C), .R(r1), .start(start1), .op(op1), .abort(abort1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ov1)
  );

  typedef struct packed {logic [7:0] s; logic c; logic v;} exp_t;
  exp_t q8[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt8 = 0;
  int last_done_cyc8 = 0;

  always @(posedge C) cyc++;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out, got no response expected one (cycle %0d)", name, cyc);
  endtask

  // Plain-arithmetic reference: unsigned sum/difference, carry = no borrow, signed overflow by sign rule.
  function automatic exp_t model(input int w, input logic [7:0] x, input logic [7:0] y, input logic o);
    longint unsigned m, xa, yb, t;
    logic sx, sy, st, c;
    exp_t e;
    m  = (64'd1 << w) - 1;
    xa = x & m;
    yb = y & m;
    if (o) begin
      c = (xa >= yb);
      t = (xa - yb) & m;
    end else begin
      t = xa + yb;
      c = ((t >> w) & 1) != 0;
      t = t & m;
    end
    sx = ((xa >> (w - 1)) & 1) != 0;
    sy = ((yb >> (w - 1)) & 1) != 0;
    st = ((t  >> (w - 1)) & 1) != 0;
    e.s = 8'(t);
    e.c = c;
    e.v = o ? ((sx != sy) && (st != sx)) : ((sx == sy) && (st != sx));
    return e;
  endfunction

  always @(negedge C) begin
    if (done8 === 1'b1) begin
      exp_t e;
      done_cnt8++;
      last_done_cyc8 = cyc;
      if (q8.size() == 0) timeout("w8_unexpected_done");
      else begin
        e = q8.pop_front();
        check("w8_sum", sum8, e.s);
        check("w8_cout", cout8, e.c);
        check("w8_ovf", ov8, e.v);
      end
    end
  end

  always @(negedge C) begin
    if (done1 === 1'b1) begin
      exp_t e;
      if (q1.size() == 0) timeout("w1_unexpected_done");
      else begin
        e = q1.pop_front();
        check("w1_sum", sum1, e.s[0]);
        check("w1_cout", cout1, e.c);
        check("w1_ovf", ov1, e.v);
      end
    end
  end

  task automatic issue8(input logic o, input logic [7:0] x, input logic [7:0] y, output int k);
    a8 = x; b8 = y; op8 = o; start8 = 1'b1;
    @(posedge C);
    #1 k = cyc;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = 1'($urandom);
  endtask

  task automatic wait_ready8(output int rc);
    rc = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge C);
      #1;
      if (ready8 === 1'b1) begin
        rc = cyc;
        return;
      end
    end
    timeout("w8_ready");
  endtask

  task automatic op8_dir(input logic o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] es, input logic ec, input logic ev);
    exp_t e;
    int k, rc;
    e.s = es; e.c = ec; e.v = ev;
    q8.push_back(e);
    issue8(o, x, y, k);
    wait_ready8(rc);
  endtask

  task automatic drive8();
    int k, rc, dc0;
    bit found;
    exp_t e;
    r8 = 1'b1; start8 = 1'b0; op8 = 1'b0; abort8 = 1'b0; a8 = '0; b8 = '0;
    #2 r8 = 1'b0;
    #1;
    check("rst_ready", ready8, 1); check("rst_busy", busy8, 0); check("rst_done", done8, 0);
    check("rst_sum", sum8, 0); check("rst_cout", cout8, 0); check("rst_ovf", ov8, 0);
    @(posedge C); @(posedge C);
    #1 r8 = 1'b1;

    // First op also measures latency and turnaround.
    e.s = 8'h96; e.c = 1'b0; e.v = 1'b1;
    q8.push_back(e);
    dc0 = done_cnt8;
    issue8(1'b0, 8'h5A, 8'h3C, k);
    check("accept_ready_low", ready8, 0);
    wait_ready8(rc);
    check("latency_done", last_done_cyc8, k + 8);
    check("latency_ready", rc, k + 9);
    check("single_done", done_cnt8 - dc0, 1);

    op8_dir(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    op8_dir(1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    op8_dir(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    op8_dir(1'b1, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0);

    // Start pulses during RUN and DONE must be ignored.
    dc0 = done_cnt8;
    q8.push_back(model(8, 8'h12, 8'h34, 1'b0));
    issue8(1'b0, 8'h12, 8'h34, k);
    repeat (3) @(posedge C);
    #1 a8 = 8'hFF; b8 = 8'hFF; op8 = 1'b1; start8 = 1'b1;
    @(posedge C);
    #1 start8 = 1'b0;
    check("busy_in_run", busy8, 1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8 === 1'b1) begin found = 1; break; end
      @(posedge C);
      #1;
    end
    if (!found) timeout("w8_done_wait");
    a8 = 8'h77; b8 = 8'h01; start8 = 1'b1;
    @(posedge C);
    #1 start8 = 1'b0;
    check("ready_after_done", ready8, 1);
    repeat (12) @(posedge C);
    #1;
    check("ignored_starts_one_done", done_cnt8 - dc0, 1);
    check("ignored_starts_idle", busy8, 0);

    // Abort after a known 8'h96 result.
    op8_dir(1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    dc0 = done_cnt8;
    issue8(1'b0, 8'h01, 8'h01, k);
    repeat (3) @(posedge C);
    #1 abort8 = 1'b1;
    @(posedge C);
    #1 abort8 = 1'b0;
    check("abort_ready", ready8, 1);
    check("abort_busy", busy8, 0);
    repeat (12) @(posedge C);
    #1;
    check("abort_no_done", done_cnt8 - dc0, 0);
    check("abort_sum_hold", sum8, 8'h96);
    check("abort_cout_hold", cout8, 0);
    check("abort_ovf_hold", ov8, 1);

    // Asynchronous reset in the middle of RUN.
    issue8(1'b0, 8'h77, 8'h11, k);
    repeat (3) @(posedge C);
    #3 r8 = 1'b0;
    #1;
    check("midrst_ready", ready8, 1); check("midrst_busy", busy8, 0); check("midrst_done", done8, 0);
    check("midrst_sum", sum8, 0); check("midrst_cout", cout8, 0); check("midrst_ovf", ov8, 0);
    @(posedge C);
    #1 r8 = 1'b1;

    for (int i = 0; i < 200; i++) begin
      logic o;
      logic [7:0] x, y;
      o = 1'($urandom_range(0, 1));
      x = 8'($urandom);
      y = 8'($urandom);
      q8.push_back(model(8, x, y, o));
      issue8(o, x, y, k);
      wait_ready8(rc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge C);
      #0;
    end
    repeat (3) @(posedge C);
    check("w8_queue_drained", q8.size(), 0);
  endtask

  task automatic drive1();
    int rc;
    r1 = 1'b1; start1 = 1'b0; op1 = 1'b0; abort1 = 1'b0; a1 = '0; b1 = '0;
    #2 r1 = 1'b0;
    @(posedge C); @(posedge C);
    #1 r1 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic o;
      logic [7:0] x, y;
      o = 1'($urandom_range(0, 1));
      x = 8'($urandom_range(0, 1));
      y = 8'($urandom_range(0, 1));
      q1.push_back(model(1, x, y, o));
      a1 = x[0:0]; b1 = y[0:0]; op1 = o; start1 = 1'b1;
      @(posedge C);
      #1 start1 = 1'b0;
      a1 = 1'($urandom); b1 = 1'($urandom); op1 = 1'($urandom);
      rc = -1;
      for (int j = 0; j < 10; j++) begin
        @(posedge C);
        #1;
        if (ready1 === 1'b1) begin rc = j; break; end
      end
      if (rc < 0) timeout("w1_ready");
    end
    repeat (3) @(posedge C);
    check("w1_queue_drained", q1.size(), 0);
  endtask

  initial begin
    fork
      drive8();
      drive1();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation got stuck, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
